// File: rtl/pe_seq_ctrl_if.sv
// Bundle between the SD4 PE sequencer and its neighbours: weight push port,
// job start, PE drive/return signals and the valid/ready result port.
interface pe_seq_ctrl_if #(
  parameter int IMG_W  = 24,
  parameter int WGT_W  = 36,
  parameter int PSUM_W = 16,
  parameter int EXP_W  = 5,
  parameter int CNT_W  = 4
);
  logic [WGT_W-1:0]  wgt_in;
  logic              wgt_valid;
  logic              wgt_ready;
  logic              start;
  logic [CNT_W-1:0]  num_terms;
  logic [IMG_W-1:0]  image_in;
  logic [EXP_W-1:0]  exp_bias_in;
  logic [PSUM_W-1:0] psum_init;
  logic              pe_en;
  logic [IMG_W-1:0]  pe_image;
  logic [EXP_W-1:0]  pe_exp_bias;
  logic [WGT_W-1:0]  pe_weight;
  logic [PSUM_W-1:0] pe_psum;
  logic [PSUM_W-1:0] pe_psum_out;
  logic              busy;
  logic              res_valid;
  logic [PSUM_W-1:0] res_data;
  logic              res_ready;

  modport slave (
    input  wgt_in, wgt_valid, start, num_terms, image_in, exp_bias_in,
           psum_init, pe_psum_out, res_ready,
    output wgt_ready, pe_en, pe_image, pe_exp_bias, pe_weight, pe_psum,
           busy, res_valid, res_data
  );

  modport master (
    output wgt_in, wgt_valid, start, num_terms, image_in, exp_bias_in,
           psum_init, pe_psum_out, res_ready,
    input  wgt_ready, pe_en, pe_image, pe_exp_bias, pe_weight, pe_psum,
           busy, res_valid, res_data
  );
endinterface

// File: rtl/pe_seq_ctrl.sv
// Sequencer for the SD4 MAC PE: buffers weight words, issues one PE op per
// term, chains psum_out back into psum and returns the final partial sum.
module pe_seq_ctrl #(
  parameter int IMG_W  = 24,
  parameter int WGT_W  = 36,
  parameter int PSUM_W = 16,
  parameter int EXP_W  = 5,
  parameter int DEPTH  = 8,
  parameter int PE_LAT = 4,
  parameter int CNT_W  = 4
) (
  input  logic         clk,
  input  logic         rst,
  pe_seq_ctrl_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(PE_LAT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;
  state_t state, state_n;

  logic [WGT_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, empty, push, pop, cap, pe_en;
  logic [WGT_W-1:0]  head;

  logic [IMG_W-1:0]  image_q;
  logic [EXP_W-1:0]  exp_q;
  logic [WGT_W-1:0]  wgt_q;
  logic [PSUM_W-1:0] psum_q, res_q;
  logic [CNT_W-1:0]  remaining;
  logic [LW-1:0]     lat_cnt;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.wgt_valid && !full;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wgt_in;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    pe_en   = 1'b0;
    pop     = 1'b0;
    cap     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_n = (bus.num_terms == '0) ? DONE : FETCH;
      end
      FETCH: begin
        if (!empty) begin
          pe_en   = 1'b1;
          pop     = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        // Counter hits zero on this edge: PE result is valid now.
        if (lat_cnt == LW'(1)) begin
          cap     = 1'b1;
          state_n = (remaining == CNT_W'(1)) ? DONE : FETCH;
        end
      end
      DONE: begin
        if (bus.res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      image_q   <= '0;
      exp_q     <= '0;
      wgt_q     <= '0;
      psum_q    <= '0;
      res_q     <= '0;
      remaining <= '0;
      lat_cnt   <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        image_q   <= bus.image_in;
        exp_q     <= bus.exp_bias_in;
        psum_q    <= bus.psum_init;
        remaining <= bus.num_terms;
        if (bus.num_terms == '0) res_q <= bus.psum_init;
      end
      if (pop) begin
        wgt_q   <= head;
        lat_cnt <= LW'(PE_LAT);
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (cap) begin
        psum_q    <= bus.pe_psum_out;
        remaining <= remaining - 1'b1;
        if (remaining == CNT_W'(1)) res_q <= bus.pe_psum_out;
      end
    end
  end

  // FIFO head is shown during the issue cycle, then held until the next pop.
  assign bus.pe_weight   = (state == FETCH && !empty) ? head : wgt_q;
  assign bus.wgt_ready   = !full;
  assign bus.pe_en       = pe_en;
  assign bus.pe_image    = image_q;
  assign bus.pe_exp_bias = exp_q;
  assign bus.pe_psum     = psum_q;
  assign bus.busy        = (state != IDLE);
  assign bus.res_valid   = (state == DONE);
  assign bus.res_data    = res_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl with a PE stub returning psum + weight[15:0]
// after PE_LAT edges.
`timescale 1ns/1ps
module tb_pe_seq_ctrl;
  localparam int IMG_W = 24, WGT_W = 36, PSUM_W = 16, EXP_W = 5;
  localparam int DEPTH = 8, PE_LAT = 4, CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_seq_ctrl_if #(.IMG_W(IMG_W), .WGT_W(WGT_W), .PSUM_W(PSUM_W),
                   .EXP_W(EXP_W), .CNT_W(CNT_W)) bus ();

  pe_seq_ctrl #(.IMG_W(IMG_W), .WGT_W(WGT_W), .PSUM_W(PSUM_W), .EXP_W(EXP_W),
                .DEPTH(DEPTH), .PE_LAT(PE_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // PE stub: result is presented only during the single cycle it is due.
  logic [PE_LAT-1:0]             stub_v;
  logic [PE_LAT-1:0][PSUM_W-1:0] stub_d;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_v <= '0;
      stub_d <= '0;
    end else begin
      stub_v <= {stub_v[PE_LAT-2:0], bus.pe_en};
      stub_d <= {stub_d[PE_LAT-2:0], bus.pe_psum + bus.pe_weight[15:0]};
    end
  end
  assign bus.pe_psum_out = stub_v[PE_LAT-1] ? stub_d[PE_LAT-1] : 16'hBAD0;

  // Log of the cycle number of every edge that samples pe_en=1.
  int cyc = 0;
  int n_en = 0;
  int en_log [256];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.pe_en) begin
      if (n_en < 256) en_log[n_en] <= cyc;
      n_en <= n_en + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [WGT_W-1:0] wq [32];
  int n_pushed = 0;
  int n_lim = 0;

  task automatic arm_push();
    if (n_pushed < n_lim) begin
      bus.wgt_valid = 1'b1;
      bus.wgt_in    = wq[n_pushed];
    end else begin
      bus.wgt_valid = 1'b0;
      bus.wgt_in    = '0;
    end
  endtask

  task automatic step();
    logic hs;
    hs = bus.wgt_valid && bus.wgt_ready;
    @(posedge clk);
    #1;
    if (hs) n_pushed++;
    arm_push();
  endtask

  task automatic load_words(input int n);
    n_pushed = 0;
    n_lim    = n;
    arm_push();
  endtask

  task automatic wait_pushes(input int target, input int max, output bit ok);
    ok = (n_pushed >= target);
    for (int i = 0; i < max && !ok; i++) begin
      step();
      ok = (n_pushed >= target);
    end
  endtask

  task automatic kick(input logic [CNT_W-1:0] n, input logic [IMG_W-1:0] img,
                      input logic [EXP_W-1:0] eb, input logic [PSUM_W-1:0] pi,
                      output int s);
    bus.start       = 1'b1;
    bus.num_terms   = n;
    bus.image_in    = img;
    bus.exp_bias_in = eb;
    bus.psum_init   = pi;
    s = cyc;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_result(input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (bus.res_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic accept();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.wgt_ready !== 1'b1 || bus.busy !== 1'b0 || bus.pe_en !== 1'b0 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%0b busy=%0b en=%0b valid=%0b, expected 1 0 0 0",
               bus.wgt_ready, bus.busy, bus.pe_en, bus.res_valid);
    end
    checks++;
    if ({bus.pe_image, bus.pe_exp_bias, bus.pe_weight, bus.pe_psum, bus.res_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: img=%h eb=%h w=%h psum=%h res=%h, expected all 0",
               bus.pe_image, bus.pe_exp_bias, bus.pe_weight, bus.pe_psum, bus.res_data);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    bit ok;
    int s, lat, base;
    wq[0] = 36'hF_0000_0003;
    wq[1] = 36'hA_0000_0005;
    wq[2] = 36'h5_0000_0007;
    load_words(3);
    wait_pushes(3, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_push: pushed %0d, expected 3", n_pushed); end
    base = n_en;
    kick(3, 24'hABCDEF, 5'h13, 16'h000F, s);
    bus.image_in = '1;
    bus.exp_bias_in = '1;
    bus.psum_init = '1;
    checks++;
    if (bus.busy !== 1'b1 || bus.pe_image !== 24'hABCDEF || bus.pe_exp_bias !== 5'h13 || bus.pe_psum !== 16'h000F) begin
      errors++;
      $display("FAIL basic_latch: busy=%0b img=%h eb=%h psum=%h, expected 1 abcdef 13 000f",
               bus.busy, bus.pe_image, bus.pe_exp_bias, bus.pe_psum);
    end
    wait_result(40, lat);
    checks++;
    if (lat !== 15) begin errors++; $display("FAIL basic_latency: got %0d edges, expected 15", lat); end
    checks++;
    if (bus.res_data !== 16'h001E) begin errors++; $display("FAIL basic_result: got %h, expected 001e", bus.res_data); end
    checks++;
    if (n_en - base !== 3) begin errors++; $display("FAIL basic_pulses: got %0d pe_en cycles, expected 3", n_en - base); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (en_log[base + k] !== s + 1 + 5 * k) begin
        errors++;
        $display("FAIL basic_en_spacing: pulse %0d at cycle %0d, expected %0d", k, en_log[base + k], s + 1 + 5 * k);
      end
    end
    checks++;
    if (bus.pe_image !== 24'hABCDEF) begin errors++; $display("FAIL basic_hold: img=%h, expected abcdef", bus.pe_image); end
    accept();
    checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_accept: valid=%0b busy=%0b, expected 0 0", bus.res_valid, bus.busy);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int s, lat, base;
    load_words(0);
    base = n_en;
    kick(2, 24'h123456, 5'h01, 16'h0100, s);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.pe_en !== 1'b0) begin errors++; $display("FAIL stall_en_low: pe_en=%0b after edge %0d, expected 0", bus.pe_en, i); end
      if (i < 5) step();
    end
    wq[0] = 36'h0_0000_0010;
    wq[1] = 36'h0_0000_0020;
    load_words(2);
    step();
    checks++;
    if (bus.pe_en !== 1'b1) begin errors++; $display("FAIL stall_en_high: pe_en=%0b after first push, expected 1", bus.pe_en); end
    step();
    wait_pushes(2, 5, ok);
    wait_result(40, lat);
    checks++;
    if (lat + 7 !== 16) begin errors++; $display("FAIL stall_latency: got %0d edges, expected 16", lat + 7); end
    checks++;
    if (en_log[base] !== s + 7) begin errors++; $display("FAIL stall_first_en: cycle %0d, expected %0d", en_log[base], s + 7); end
    checks++;
    if (bus.res_data !== 16'h0130) begin errors++; $display("FAIL stall_result: got %h, expected 0130", bus.res_data); end
    accept();
  endtask

  task automatic test_full_wrap();
    bit ok;
    int s, lat;
    logic [15:0] lo;
    logic [15:0] pi;
    logic [15:0] exp_res [3];
    exp_res[0] = 16'h10AA;
    exp_res[1] = 16'h21BA;
    exp_res[2] = 16'h32CA;
    for (int i = 0; i < 12; i++) begin
      lo = 16'(16'h0011 * (i + 1));
      wq[i] = {4'h1, 16'h0000, lo};
    end
    load_words(12);
    wait_pushes(8, 20, ok);
    checks++;
    if (bus.wgt_ready !== 1'b0 || n_pushed !== 8) begin
      errors++;
      $display("FAIL full_ready: ready=%0b pushed=%0d, expected 0 8", bus.wgt_ready, n_pushed);
    end
    step();
    step();
    checks++;
    if (bus.wgt_ready !== 1'b0 || n_pushed !== 8) begin
      errors++;
      $display("FAIL full_holdoff: ready=%0b pushed=%0d, expected 0 8", bus.wgt_ready, n_pushed);
    end
    for (int j = 0; j < 3; j++) begin
      pi = 16'(16'h1000 * (j + 1));
      kick(4, 24'h000100, 5'h04, pi, s);
      wait_result(100, lat);
      checks++;
      if (lat < 0 || bus.res_data !== exp_res[j]) begin
        errors++;
        $display("FAIL wrap_result: job %0d got %h (lat %0d), expected %h", j, bus.res_data, lat, exp_res[j]);
      end
      accept();
    end
    checks++;
    if (n_pushed !== 12) begin errors++; $display("FAIL wrap_pushes: pushed %0d, expected 12", n_pushed); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int s, lat;
    wq[0] = 36'h0_0000_0005;
    load_words(1);
    wait_pushes(1, 10, ok);
    kick(1, 24'h0F0F0F, 5'h1F, 16'h0010, s);
    wait_result(20, lat);
    checks++;
    if (lat !== 5 || bus.res_data !== 16'h0015) begin
      errors++;
      $display("FAIL bp_result: got %h lat %0d, expected 0015 lat 5", bus.res_data, lat);
    end
    bus.start = 1'b1;
    bus.num_terms = '0;
    bus.psum_init = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h0015 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d valid=%0b data=%h busy=%0b, expected 1 0015 1",
                 i, bus.res_valid, bus.res_data, bus.busy);
      end
    end
    bus.start = 1'b0;
    accept();
    checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.pe_psum !== 16'h0015) begin
      errors++;
      $display("FAIL bp_start_ignored: valid=%0b busy=%0b psum=%h, expected 0 0 0015",
               bus.res_valid, bus.busy, bus.pe_psum);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_idle: busy=%0b, expected 0", bus.busy); end
  endtask

  task automatic test_zero_terms();
    int s, base;
    base = n_en;
    kick(0, 24'h111111, 5'h02, 16'h1234, s);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h1234 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_result: valid=%0b data=%h busy=%0b, expected 1 1234 1",
               bus.res_valid, bus.res_data, bus.busy);
    end
    step();
    step();
    checks++;
    if (n_en !== base || bus.res_valid !== 1'b1) begin
      errors++;
      $display("FAIL zero_no_en: pe_en cycles %0d valid=%0b, expected 0 1", n_en - base, bus.res_valid);
    end
    accept();
  endtask

  task automatic test_mid_reset();
    bit ok;
    int s, lat, base;
    wq[0] = 36'h0_0000_0001;
    wq[1] = 36'h0_0000_0002;
    wq[2] = 36'h0_0000_0003;
    wq[3] = 36'h0_0000_0004;
    for (int i = 4; i < 9; i++) wq[i] = 36'h0_0000_0100;
    load_words(9);
    wait_pushes(8, 20, ok);
    base = n_en;
    kick(4, 24'hCAFE00, 5'h0A, 16'h0000, s);
    for (int i = 0; i < 20 && (n_en - base) < 1; i++) step();
    step();
    step();
    checks++;
    if (bus.wgt_ready !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: ready=%0b busy=%0b, expected 0 1", bus.wgt_ready, bus.busy);
    end
    #2;
    rst = 1'b1;
    load_words(0);
    #1;
    checks++;
    if (bus.wgt_ready !== 1'b1 || bus.busy !== 1'b0 || bus.pe_en !== 1'b0 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_ctrl: ready=%0b busy=%0b en=%0b valid=%0b, expected 1 0 0 0",
               bus.wgt_ready, bus.busy, bus.pe_en, bus.res_valid);
    end
    checks++;
    if ({bus.pe_image, bus.pe_exp_bias, bus.pe_weight, bus.pe_psum, bus.res_data} !== '0) begin
      errors++;
      $display("FAIL rst_async_data: img=%h eb=%h w=%h psum=%h res=%h, expected all 0",
               bus.pe_image, bus.pe_exp_bias, bus.pe_weight, bus.pe_psum, bus.res_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    wq[0] = 36'h0_0000_0007;
    wq[1] = 36'h0_0000_0008;
    load_words(2);
    wait_pushes(2, 10, ok);
    base = n_en;
    kick(2, 24'h0000AA, 5'h03, 16'h0001, s);
    wait_result(40, lat);
    checks++;
    if (lat !== 10 || bus.res_data !== 16'h0010 || n_en - base !== 2) begin
      errors++;
      $display("FAIL rst_new_job: data=%h lat=%0d pulses=%0d, expected 0010 10 2",
               bus.res_data, lat, n_en - base);
    end
    accept();
  endtask

  initial begin
    rst             = 1'b1;
    bus.wgt_valid   = 1'b0;
    bus.wgt_in      = '0;
    bus.start       = 1'b0;
    bus.num_terms   = '0;
    bus.image_in    = '0;
    bus.exp_bias_in = '0;
    bus.psum_init   = '0;
    bus.res_ready   = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_full_wrap();
    test_backpressure();
    test_zero_terms();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 ns, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
